// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: sync, blanking, clamped beam coordinates, event strobes
// and a prefetch coordinate port leading the beam. VGA_TIMING_FRAME_CNT_EN adds an 8-bit frame counter.
module vga_timing_gen #(
    parameter int   H_ACTIVE   = 640,
    parameter int   H_FRONT    = 16,
    parameter int   H_SYNC     = 96,
    parameter int   H_BACK     = 48,
    parameter int   V_ACTIVE   = 480,
    parameter int   V_FRONT    = 10,
    parameter int   V_SYNC     = 2,
    parameter int   V_BACK     = 33,
    parameter logic H_SYNC_POL = 1'b0,
    parameter logic V_SYNC_POL = 1'b0,
    parameter int   PREFETCH   = 2,
    parameter int   X_W        = 10,
    parameter int   Y_W        = 10
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_pix_stb,
    output logic           o_hs,
    output logic           o_vs,
    output logic           o_active,
    output logic           o_blanking,
    output logic [X_W-1:0] o_x,
    output logic [Y_W-1:0] o_y,
    output logic           o_line_end,
    output logic           o_animate,
    output logic           o_frame_end,
    output logic [X_W-1:0] o_fetch_x,
    output logic [Y_W-1:0] o_fetch_y,
    output logic           o_fetch_valid
`ifdef VGA_TIMING_FRAME_CNT_EN
   ,output logic [7:0]     o_frame
`endif
);

    localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_ACTIVE + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC;

    localparam logic [X_W-1:0] H_LAST     = X_W'(H_TOTAL - 1);
    localparam logic [Y_W-1:0] V_LAST     = Y_W'(V_TOTAL - 1);
    localparam logic [X_W-1:0] H_ACT_LAST = X_W'(H_ACTIVE - 1);
    localparam logic [Y_W-1:0] V_ACT_LAST = Y_W'(V_ACTIVE - 1);
    localparam logic [X_W-1:0] X_ZERO     = {X_W{1'b0}};
    localparam logic [Y_W-1:0] Y_ZERO     = {Y_W{1'b0}};

    // The prefetch pair starts PREFETCH pixels into line 0 (PREFETCH < H_TOTAL).
    localparam logic [X_W-1:0] FH_RST     = X_W'(PREFETCH);
    localparam logic [X_W-1:0] FX_RST     = (PREFETCH < H_ACTIVE) ? FH_RST : H_ACT_LAST;
    localparam logic           FVALID_RST = (PREFETCH < H_ACTIVE) ? 1'b1 : 1'b0;

    logic [X_W-1:0] h_r, fh_r, h_nxt_s, fh_nxt_s;
    logic [Y_W-1:0] v_r, fv_r, v_nxt_s, fv_nxt_s;
    logic           hs_nxt_s, vs_nxt_s, active_nxt_s, fvalid_nxt_s;
    logic [X_W-1:0] x_nxt_s, fx_nxt_s;
    logic [Y_W-1:0] y_nxt_s, fy_nxt_s;
    logic           line_end_s, frame_end_s;

    function automatic logic in_range(input int val, input int lo, input int hi);
        return (val >= lo) && (val < hi);
    endfunction

    function automatic logic [Y_W+X_W-1:0] beam_step(input logic [X_W-1:0] h, input logic [Y_W-1:0] v);
        logic [X_W-1:0] hn;
        logic [Y_W-1:0] vn;
        if (h == H_LAST) begin
            hn = X_ZERO;
            vn = (v == V_LAST) ? Y_ZERO : v + Y_W'(1'b1);
        end else begin
            hn = h + X_W'(1'b1);
            vn = v;
        end
        return {vn, hn};
    endfunction

    // Position of beam and prefetch pairs after this clock (reset handled in the registers).
    always_comb begin
        h_nxt_s  = h_r;
        v_nxt_s  = v_r;
        fh_nxt_s = fh_r;
        fv_nxt_s = fv_r;
        if (i_pix_stb) begin
            {v_nxt_s, h_nxt_s}   = beam_step(h_r, v_r);
            {fv_nxt_s, fh_nxt_s} = beam_step(fh_r, fv_r);
        end else begin
            h_nxt_s  = h_r;
            v_nxt_s  = v_r;
            fh_nxt_s = fh_r;
            fv_nxt_s = fv_r;
        end
    end

    // Decode of the upcoming position so registered outputs track the counters with no lag.
    always_comb begin
        hs_nxt_s     = in_range(int'(h_nxt_s), HS_START, HS_END) ? H_SYNC_POL : ~H_SYNC_POL;
        vs_nxt_s     = in_range(int'(v_nxt_s), VS_START, VS_END) ? V_SYNC_POL : ~V_SYNC_POL;
        active_nxt_s = (int'(h_nxt_s) < H_ACTIVE) && (int'(v_nxt_s) < V_ACTIVE);
        x_nxt_s      = (int'(h_nxt_s) < H_ACTIVE) ? h_nxt_s : H_ACT_LAST;
        y_nxt_s      = (int'(v_nxt_s) < V_ACTIVE) ? v_nxt_s : V_ACT_LAST;
        fvalid_nxt_s = (int'(fh_nxt_s) < H_ACTIVE) && (int'(fv_nxt_s) < V_ACTIVE);
        fx_nxt_s     = (int'(fh_nxt_s) < H_ACTIVE) ? fh_nxt_s : H_ACT_LAST;
        fy_nxt_s     = (int'(fv_nxt_s) < V_ACTIVE) ? fv_nxt_s : V_ACT_LAST;
    end

    // Beam and prefetch counters.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            h_r  <= X_ZERO;
            v_r  <= Y_ZERO;
            fh_r <= FH_RST;
            fv_r <= Y_ZERO;
        end else begin
            h_r  <= h_nxt_s;
            v_r  <= v_nxt_s;
            fh_r <= fh_nxt_s;
            fv_r <= fv_nxt_s;
        end
    end

    // Registered sync, blanking and coordinate outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_hs          <= ~H_SYNC_POL;
            o_vs          <= ~V_SYNC_POL;
            o_active      <= 1'b1;
            o_blanking    <= 1'b0;
            o_x           <= X_ZERO;
            o_y           <= Y_ZERO;
            o_fetch_x     <= FX_RST;
            o_fetch_y     <= Y_ZERO;
            o_fetch_valid <= FVALID_RST;
        end else begin
            o_hs          <= hs_nxt_s;
            o_vs          <= vs_nxt_s;
            o_active      <= active_nxt_s;
            o_blanking    <= ~active_nxt_s;
            o_x           <= x_nxt_s;
            o_y           <= y_nxt_s;
            o_fetch_x     <= fx_nxt_s;
            o_fetch_y     <= fy_nxt_s;
            o_fetch_valid <= fvalid_nxt_s;
        end
    end

    // Event strobes are combinational; a reset in the same clock suppresses them.
    assign line_end_s  = i_pix_stb & ~i_rst & (h_r == H_LAST);
    assign frame_end_s = line_end_s & (v_r == V_LAST);
    assign o_line_end  = line_end_s;
    assign o_animate   = line_end_s & (v_r == V_ACT_LAST);
    assign o_frame_end = frame_end_s;

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [7:0] frame_r;

    // Free-running frame counter for animation timebases.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            frame_r <= 8'd0;
        end else if (frame_end_s) begin
            frame_r <= frame_r + 8'd1;
        end else begin
            frame_r <= frame_r;
        end
    end

    assign o_frame = frame_r;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance and a tiny 7x6 instance, both checked each
// cycle against a position-count model, plus literal expectations at known beam positions.
module tb_vga_timing_gen;

    localparam int AHA = 640, AHF = 16, AHS = 96, AHB = 48;
    localparam int AVA = 480, AVF = 10, AVS = 2,  AVB = 33, APF = 2;
    localparam int AHT = AHA + AHF + AHS + AHB;
    localparam int AFR = AHT * (AVA + AVF + AVS + AVB);
    localparam int BHA = 4, BHF = 1, BHS = 1, BHB = 1;
    localparam int BVA = 3, BVF = 1, BVS = 1, BVB = 1, BPF = 3;
    localparam int BHT = BHA + BHF + BHS + BHB;
    localparam int BFR = BHT * (BVA + BVF + BVS + BVB);

    typedef struct packed {
        int hs; int vs; int act; int x; int y; int fx; int fy; int fv;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic stb_a = 1'b0, rst_a = 1'b1, stb_b = 1'b0, rst_b = 1'b1;
    logic a_hs, a_vs, a_act, a_blk, a_le, a_an, a_fe, a_fv;
    logic [9:0] a_x, a_y, a_fx, a_fy;
    logic b_hs, b_vs, b_act, b_blk, b_le, b_an, b_fe, b_fv;
    logic [2:0] b_x, b_y, b_fx, b_fy;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [7:0] a_frame, b_frame;
`endif

    int errors = 0;
    int checks = 0;
    int pos_a = 0, pos_b = 0, fc_a = 0, fc_b = 0;
    bit live_a = 1'b0, live_b = 1'b0;
    logic le_a_q, fe_b_q;
    exp_t ea, eb;

    vga_timing_gen u_a (
        .i_clk(clk), .i_rst(rst_a), .i_pix_stb(stb_a),
        .o_hs(a_hs), .o_vs(a_vs), .o_active(a_act), .o_blanking(a_blk),
        .o_x(a_x), .o_y(a_y), .o_line_end(a_le), .o_animate(a_an), .o_frame_end(a_fe),
        .o_fetch_x(a_fx), .o_fetch_y(a_fy), .o_fetch_valid(a_fv)
`ifdef VGA_TIMING_FRAME_CNT_EN
       ,.o_frame(a_frame)
`endif
    );

    vga_timing_gen #(
        .H_ACTIVE(BHA), .H_FRONT(BHF), .H_SYNC(BHS), .H_BACK(BHB),
        .V_ACTIVE(BVA), .V_FRONT(BVF), .V_SYNC(BVS), .V_BACK(BVB),
        .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .PREFETCH(BPF), .X_W(3), .Y_W(3)
    ) u_b (
        .i_clk(clk), .i_rst(rst_b), .i_pix_stb(stb_b),
        .o_hs(b_hs), .o_vs(b_vs), .o_active(b_act), .o_blanking(b_blk),
        .o_x(b_x), .o_y(b_y), .o_line_end(b_le), .o_animate(b_an), .o_frame_end(b_fe),
        .o_fetch_x(b_fx), .o_fetch_y(b_fy), .o_fetch_valid(b_fv)
`ifdef VGA_TIMING_FRAME_CNT_EN
       ,.o_frame(b_frame)
`endif
    );

    // Expected registered outputs for a beam that has taken p strobes since reset.
    function automatic exp_t model(input int p, input int ha, input int hf, input int hs, input int hb,
                                   input int va, input int vf, input int vs, input int vb,
                                   input int hp, input int vp, input int pf);
        exp_t m;
        int ht, vt, h, v, q, fh, fv;
        ht = ha + hf + hs + hb;
        vt = va + vf + vs + vb;
        h = p % ht;
        v = p / ht;
        q = (p + pf) % (ht * vt);
        fh = q % ht;
        fv = q / ht;
        m.hs  = (h >= ha + hf && h < ha + hf + hs) ? hp : 1 - hp;
        m.vs  = (v >= va + vf && v < va + vf + vs) ? vp : 1 - vp;
        m.act = (h < ha && v < va) ? 1 : 0;
        m.x   = (h < ha) ? h : ha - 1;
        m.y   = (v < va) ? v : va - 1;
        m.fx  = (fh < ha) ? fh : ha - 1;
        m.fy  = (fv < va) ? fv : va - 1;
        m.fv  = (fh < ha && fv < va) ? 1 : 0;
        return m;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: strobe counts since reset, frame event counts.
    always @(posedge clk) begin
        if (rst_a) begin
            pos_a <= 0; fc_a <= 0; live_a <= 1'b1;
        end else if (stb_a) begin
            pos_a <= (pos_a + 1) % AFR;
            if (pos_a == AFR - 1) fc_a <= (fc_a + 1) % 256;
        end
        if (rst_b) begin
            pos_b <= 0; fc_b <= 0; live_b <= 1'b1;
        end else if (stb_b) begin
            pos_b <= (pos_b + 1) % BFR;
            if (pos_b == BFR - 1) fc_b <= (fc_b + 1) % 256;
        end
    end

    // Per-cycle compare of both instances against the model.
    always @(negedge clk) begin
        int le;
        if (live_a) begin
            ea = model(pos_a, AHA, AHF, AHS, AHB, AVA, AVF, AVS, AVB, 0, 0, APF);
            le = (stb_a && !rst_a && (pos_a % AHT) == AHT - 1) ? 1 : 0;
            chk("a_hs", int'(a_hs), ea.hs);      chk("a_vs", int'(a_vs), ea.vs);
            chk("a_active", int'(a_act), ea.act); chk("a_blanking", int'(a_blk), 1 - ea.act);
            chk("a_x", int'(a_x), ea.x);          chk("a_y", int'(a_y), ea.y);
            chk("a_fetch_x", int'(a_fx), ea.fx);  chk("a_fetch_y", int'(a_fy), ea.fy);
            chk("a_fetch_valid", int'(a_fv), ea.fv);
            chk("a_line_end", int'(a_le), le);
            chk("a_animate", int'(a_an), (le == 1 && pos_a / AHT == AVA - 1) ? 1 : 0);
            chk("a_frame_end", int'(a_fe), (le == 1 && pos_a == AFR - 1) ? 1 : 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
            chk("a_frame", int'(a_frame), fc_a);
`endif
        end
        if (live_b) begin
            eb = model(pos_b, BHA, BHF, BHS, BHB, BVA, BVF, BVS, BVB, 1, 1, BPF);
            le = (stb_b && !rst_b && (pos_b % BHT) == BHT - 1) ? 1 : 0;
            chk("b_hs", int'(b_hs), eb.hs);      chk("b_vs", int'(b_vs), eb.vs);
            chk("b_active", int'(b_act), eb.act); chk("b_blanking", int'(b_blk), 1 - eb.act);
            chk("b_x", int'(b_x), eb.x);          chk("b_y", int'(b_y), eb.y);
            chk("b_fetch_x", int'(b_fx), eb.fx);  chk("b_fetch_y", int'(b_fy), eb.fy);
            chk("b_fetch_valid", int'(b_fv), eb.fv);
            chk("b_line_end", int'(b_le), le);
            chk("b_animate", int'(b_an), (le == 1 && pos_b / BHT == BVA - 1) ? 1 : 0);
            chk("b_frame_end", int'(b_fe), (le == 1 && pos_b == BFR - 1) ? 1 : 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
            chk("b_frame", int'(b_frame), fc_b);
`endif
        end
    end

    // Drive one clock of inputs; strobes are captured just before the edge.
    task automatic step(input logic sa, input logic ra, input logic sb, input logic rb);
        stb_a = sa; rst_a = ra; stb_b = sb; rst_b = rb;
        #1;
        le_a_q = a_le;
        fe_b_q = b_fe;
        @(posedge clk);
        #2;
    endtask

    initial begin
        int last, cnt, hs_low, c_hs, c_vs, c_act, c_fv;
        step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        chk("a_rst_x", int'(a_x), 0);          chk("a_rst_hs", int'(a_hs), 1);
        chk("a_rst_vs", int'(a_vs), 1);        chk("a_rst_active", int'(a_act), 1);
        chk("a_rst_fetch_x", int'(a_fx), 2);   chk("a_rst_fetch_valid", int'(a_fv), 1);
        chk("b_rst_hs", int'(b_hs), 0);        chk("b_rst_fetch_x", int'(b_fx), 3);

        // Default mode, strobe every clock: line period, hsync window, prefetch wrap.
        last = 0; cnt = 0; hs_low = 0;
        for (int k = 1; k <= 5100; k++) begin
            step(1'b1, 1'b0, 1'b0, 1'b1);
            if (le_a_q) begin
                if (last != 0) chk("a_line_period", k - last, 800);
                last = k;
                cnt++;
            end
            if (k >= 801 && k <= 1600 && a_hs == 1'b0) hs_low++;
            if (k == 655) chk("a_hs_at_655", int'(a_hs), 1);
            if (k == 656) chk("a_hs_at_656", int'(a_hs), 0);
            if (k == 751) chk("a_hs_at_751", int'(a_hs), 0);
            if (k == 752) chk("a_hs_at_752", int'(a_hs), 1);
            if (k == 4798) begin
                chk("a_798_5_fetch_x", int'(a_fx), 0);  chk("a_798_5_fetch_y", int'(a_fy), 6);
                chk("a_798_5_fetch_valid", int'(a_fv), 1);
                chk("a_798_5_x", int'(a_x), 639);       chk("a_798_5_y", int'(a_y), 5);
            end
        end
        chk("a_line_pulses", cnt, 6);
        chk("a_hs_low_width", hs_low, 96);

        // Reset with strobe high mid-line, then at the last pixel of a line.
        step(1'b1, 1'b1, 1'b0, 1'b1);
        chk("a_rst_mid_no_line_end", int'(le_a_q), 0);
        chk("a_rst_mid_x", int'(a_x), 0); chk("a_rst_mid_y", int'(a_y), 0);
        chk("a_rst_mid_active", int'(a_act), 1);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        chk("a_after_rst_x", int'(a_x), 1);
        for (int k = 0; k < 798; k++) step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        chk("a_rst_eol_no_line_end", int'(le_a_q), 0);
        chk("a_rst_eol_y", int'(a_y), 0);

        // Random strobes with occasional resets.
        for (int k = 0; k < 4000; k++)
            step($urandom_range(0, 3) == 0, $urandom_range(0, 1999) == 0, 1'b0, 1'b1);

        // Strobe every 4th clock: one line_end cycle per 800 strobes.
        step(1'b0, 1'b1, 1'b0, 1'b1);
        cnt = 0;
        for (int k = 0; k < 3200; k++) begin
            step((k % 4) == 0, 1'b0, 1'b0, 1'b1);
            if (le_a_q) cnt++;
        end
        chk("a_div4_line_end_cycles", cnt, 1);

        // Tiny mode: reset state and an exhaustive walk of one frame.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("b_rst_vs", int'(b_vs), 0);        chk("b_rst_fetch_y", int'(b_fy), 0);
        chk("b_rst_fetch_valid", int'(b_fv), 1); chk("b_rst_active", int'(b_act), 1);
        c_hs = 0; c_vs = 0; c_act = 0; c_fv = 0;
        for (int k = 1; k <= BFR; k++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0);
            chk("b_walk_hs", int'(b_hs), ((k % BHT) == 5) ? 1 : 0);
            chk("b_walk_vs", int'(b_vs), (((k % BFR) / BHT) == 4) ? 1 : 0);
            c_hs += int'(b_hs); c_vs += int'(b_vs); c_act += int'(b_act); c_fv += int'(b_fv);
        end
        chk("b_hs_high_count", c_hs, 6);   chk("b_vs_high_count", c_vs, 7);
        chk("b_active_count", c_act, 12);  chk("b_fetch_valid_count", c_fv, 12);

        for (int k = 0; k < 3000; k++)
            step(1'b0, 1'b0, $urandom_range(0, 1) == 1, $urandom_range(0, 499) == 0);

        // 256 frames in tiny mode: frame counter wraps back to zero.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        cnt = 0;
        for (int k = 1; k <= 255 * BFR; k++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0);
            if (fe_b_q) cnt++;
        end
`ifdef VGA_TIMING_FRAME_CNT_EN
        chk("b_frame_255", int'(b_frame), 255);
`endif
        for (int k = 1; k <= BFR; k++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0);
            if (fe_b_q) cnt++;
        end
        chk("b_frame_end_pulses", cnt, 256);
`ifdef VGA_TIMING_FRAME_CNT_EN
        chk("b_frame_wrap", int'(b_frame), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
